// File: rtl/jk_pkg.sv
// Shared definitions for the JK-cell counter: mode encoding and the JK
// next-state rule used by every cell.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_RAW   = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous active-high clear and enable.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= 1'b0;
    end else if (en) begin
      q_q <= jk_next(q_q, j, k);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_counter.sv
// Modulo-MODULUS up/down/load counter built from WIDTH JK cells; COUNT, LOAD
// and HOLD are mapped onto toggle requests, RAW_JK drives the cells directly.
module jk_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $fatal(1, "jk_counter: WIDTH out of range 1..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "jk_counter: MODULUS out of range 2..2**WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_N  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MOD_M1 = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_cur;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic             wrap_q;
  logic             wrap_d;

  assign q_ext = {1'b0, q_cur};

  always_comb begin
    n = q_cur;
    case (mode)
      MODE_COUNT: begin
        if (up) begin
          n = (q_ext >= MOD_M1) ? '0 : q_cur + WIDTH'(1);
        end else begin
          // Out-of-range values recover to the top of the range going down.
          n = (q_ext == '0 || q_ext >= MOD_N) ? MAX_Q : q_cur - WIDTH'(1);
        end
      end
      MODE_LOAD: n = ({1'b0, d} < MOD_N) ? d : MAX_Q;
      default:   n = q_cur;
    endcase
  end

  always_comb begin
    if (mode == MODE_RAW) begin
      cell_j = j;
      cell_k = k;
    end else begin
      cell_j = n ^ q_cur;
      cell_k = n ^ q_cur;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .clr (clr),
      .en  (en),
      .j   (cell_j[i]),
      .k   (cell_k[i]),
      .q   (q_cur[i])
    );
  end

  assign tc = en && (mode == MODE_COUNT) && (up ? (q_cur == MAX_Q) : (q_cur == '0));

  // A terminal count with COUNT active is exactly the wrapping transition.
  assign wrap_d = tc;

  always_ff @(posedge clk) begin
    if (clr) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_cur;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_counter.sv
// Scoreboard bench for jk_counter (WIDTH=4, MODULUS=10): directed scenarios
// followed by random traffic, checked against an integer reference model.
module tb_jk_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         up = 1'b1;
  logic [W-1:0] d = '0;
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;

  jk_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk  (clk),
    .clr  (clr),
    .en   (en),
    .mode (mode),
    .up   (up),
    .d    (d),
    .j    (j),
    .k    (k),
    .q    (q),
    .tc   (tc),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int w;
    int tc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   mq = 0;

  task automatic check(input string name, input logic [W-1:0] act, input int expv);
    n_checks++;
    if (act !== W'(expv)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Apply one cycle of stimulus and queue what the counter must show.
  task automatic drive(input int c, input int e, input int m, input int u,
                       input int dd, input int jj, input int kk);
    exp_t x;
    int   nq;
    int   nw;
    @(negedge clk);
    clr  = c[0];
    en   = e[0];
    mode = m[1:0];
    up   = u[0];
    d    = dd[W-1:0];
    j    = jj[W-1:0];
    k    = kk[W-1:0];
    x.tc = (e != 0 && m == 0 && (u != 0 ? mq == M - 1 : mq == 0)) ? 1 : 0;
    nq = mq;
    nw = 0;
    if (c != 0) begin
      nq = 0;
    end else if (e != 0) begin
      case (m)
        0: begin
          if (u != 0) begin
            nq = (mq >= M - 1) ? 0 : mq + 1;
            nw = (mq == M - 1) ? 1 : 0;
          end else begin
            nq = (mq == 0 || mq >= M) ? M - 1 : mq - 1;
            nw = (mq == 0) ? 1 : 0;
          end
        end
        1: nq = (dd < M) ? dd : M - 1;
        2: begin
          nq = 0;
          for (int b = 0; b < W; b++) begin
            int qb, jb, kb, r;
            qb = (mq >> b) & 1;
            jb = (jj >> b) & 1;
            kb = (kk >> b) & 1;
            if (jb == 0 && kb == 0) r = qb;
            else if (jb == 0) r = 0;
            else if (kb == 0) r = 1;
            else r = 1 - qb;
            nq += r << b;
          end
        end
        default: nq = mq;
      endcase
    end
    mq = nq;
    x.q = nq;
    x.w = nw;
    sb.push_back(x);
  endtask

  // Monitor: tc just before the edge, q/wrap just after it.
  initial begin
    logic tc_s;
    exp_t x;
    forever begin
      @(negedge clk);
      #3;
      tc_s = tc;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("tc", {3'b000, tc_s}, x.tc);
        check("q", q, x.q);
        check("wrap", {3'b000, wrap}, x.w);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int C = 0, L = 1, R = 2, H = 3;

  initial begin
    int waited;
    // Reset, then count up through a wrap.
    drive(1, 0, C, 1, 0, 0, 0);
    drive(1, 1, C, 1, 0, 0, 0);
    repeat (12) drive(0, 1, C, 1, 0, 0, 0);
    // Count down from zero.
    drive(1, 1, C, 0, 0, 0, 0);
    repeat (3) drive(0, 1, C, 0, 0, 0, 0);
    // Load with clamp, held for three cycles.
    drive(0, 1, L, 1, 7, 0, 0);
    repeat (3) drive(0, 1, L, 1, 12, 0, 0);
    // Raw JK sequence from zero.
    drive(1, 1, C, 1, 0, 0, 0);
    drive(0, 1, R, 1, 0, 'b1010, 'b0000);
    drive(0, 1, R, 1, 0, 'b1111, 'b1111);
    drive(0, 1, R, 1, 0, 'b0000, 'b1111);
    drive(0, 1, R, 1, 0, 'b0000, 'b0000);
    // Out-of-range recovery in both directions.
    drive(0, 1, R, 1, 0, 'b1100, 'b0011);
    drive(0, 1, C, 1, 0, 0, 0);
    drive(0, 1, R, 1, 0, 'b1100, 'b0011);
    drive(0, 1, C, 0, 0, 0, 0);
    // Clear wins over a pending load; freeze at terminal count.
    drive(1, 1, C, 1, 0, 0, 0);
    repeat (5) drive(0, 1, C, 1, 0, 0, 0);
    drive(1, 1, L, 1, 3, 0, 0);
    drive(0, 1, L, 1, 9, 0, 0);
    repeat (3) drive(0, 0, C, 1, 0, 0, 0);
    drive(0, 1, H, 1, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 31) == 0) ? 1 : 0,
            ($urandom_range(0, 7) != 0) ? 1 : 0,
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : C,
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)));
    end
    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_counter.md
# jk_counter

Parametrised synchronous modulo-N counter built from a bank of JK flip-flop cells. Each cell has a per-bit raw-JK override, parallel load and up/down counting. It is the multi-bit, synchronous-clear successor to the single-bit JK flip-flop primitive. It serves as the general counter/state register for sequencers and dividers in the design.

## Interface
- WIDTH, 4, number of JK cells / counter bits (1..16)
- MODULUS, 16, count wraps at MODULUS (2 ≤ MODULUS ≤ 2^WIDTH)
- clk  input  1  single clock, all state updates on rising edge
- clr  input  1  reset: synchronous, active-high; one clock domain only
- en  input  1  global enable; 0 freezes all state
- mode  input  2  00 COUNT, 01 LOAD, 10 RAW_JK, 11 HOLD
- up  input  1  COUNT direction: 1 up, 0 down
- d  input  WIDTH  parallel load value (LOAD)
- j  input  WIDTH  per-bit J (RAW_JK)
- k  input  WIDTH  per-bit K (RAW_JK)
- q  output  WIDTH  counter state, registered
- tc  output  1  terminal count, combinational
- wrap  output  1  one-cycle registered pulse after a COUNT wrap

## Operation
- Priority per edge: clr > en=0 > mode.
- clr=1: q←0, wrap←0, regardless of en/mode.
- en=0: q holds, wrap←0.
- COUNT, up=1: q≥MODULUS-1 → 0, else q+1.
- COUNT, up=0: q==0 or q≥MODULUS → MODULUS-1, else q-1.
- LOAD: q←d if d<MODULUS, else q←MODULUS-1 (clamp).
- RAW_JK: each bit i follows JK truth: 00 hold, 01 reset, 10 set, 11 toggle. There is no range check, so q may exceed MODULUS-1.
- HOLD: q holds.
- COUNT, LOAD and HOLD are realised through the cells. Control computes the desired next state n. Cell i then gets J=K=1 if n[i]≠q[i], else J=K=0. RAW_JK passes j/k straight to the cells.
- tc = en & (mode==COUNT) & (up ? q==MODULUS-1 : q==0).
- wrap←1 on an edge where COUNT is active and the transition is MODULUS-1→0 (up) or 0→MODULUS-1 (down). Otherwise wrap←0. Out-of-range recovery (q≥MODULUS) does not set wrap.
- Arithmetic is internally WIDTH+1 bits; comparisons are unsigned.

## Timing
- Reset values: q=0, wrap=0; tc=0 while clr-induced q=0 unless en, COUNT and up=0 hold (tc is combinational).
- Latency: inputs sampled at edge N, q valid after edge N (1 cycle).
- wrap is asserted in the cycle immediately after the wrapping edge, for exactly 1 cycle.
- tc is valid in the same cycle as q. tc high with en=1 guarantees a wrap on the next edge.
- clr mid-operation (any mode, any q) fully restarts the counter on that edge. Pending load/RAW data is discarded.
- Changing mode or up between edges takes effect at the next edge; there is no pipeline state.

## Structure
- Shared package jk_pkg: mode encoding constants (MODE_COUNT, MODE_LOAD, MODE_RAW, MODE_HOLD) and a function for JK next-bit evaluation.
- Sub-module jk_cell: single-bit JK flop with clk, clr (sync, active-high), en, j, k, q. It is instantiated WIDTH times by generate.
- The top level holds the next-state computation, the JK derivation, tc and the wrap register.
- Elaboration check: MODULUS in range, else $fatal.

## Test plan
All scenarios use WIDTH=4, MODULUS=10.
- Reset then count up: clr=1 for 2 cycles, then en=1, COUNT, up=1. Required response: q = 0,1,…,9,0,1; tc=1 only while q=9; wrap=1 only in the cycle with q=0 after 9.
- Count down: from q=0 with up=0. Required response: q = 9,8,7; tc=1 while q=0; wrap pulse in the cycle q=9 first appears.
- LOAD d=7 → q=7 next edge; LOAD d=12 → q=9. Hold the LOAD mode for 3 cycles and q stays stable. wrap stays 0 throughout.
- RAW_JK from q=0:
  - j=1010, k=0000 → 1010
  - j=k=1111 → 0101
  - j=0000, k=1111 → 0000
  - j=k=0000 → hold
- Out-of-range recovery: RAW to q=12 (1100). COUNT up → q=0. RAW to q=12 again, COUNT down → q=9. wrap stays 0 in both cases.
- Reset and freeze:
  - At q=5 in COUNT, assert clr together with mode=LOAD, d=3 → q=0, wrap=0.
  - en=0 in COUNT at q=9 → q holds 9, tc=0, wrap=0.
